// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
// Multi-cycle controller for the EX-stage `mul` operation. It replaces a
// single-cycle multiplier with an iterative radix-2 shift-add loop and returns
// the low WIDTH bits of A*B. While the loop runs it holds IF/ID/EX through
// Stall. Non-mul operations never touch this block.
//
// The low WIDTH bits of a two's-complement product equal the low WIDTH bits
// of the unsigned product, so the loop is purely unsigned.
//
// Ports:
//   Clk         in   rising-edge clock
//   Reset       in   synchronous, active-high reset (beats Flush and Start)
//   Start       in   a valid (non-bubble) instruction sits in EX this cycle
//   ALUControl  in   ALU operation code of the EX instruction
//   A           in   multiplicand (rs after forwarding), sampled only at accept
//   B           in   multiplier   (rt after forwarding), sampled only at accept
//   Flush       in   squash of the EX instruction (aborts a running multiply)
//   Stall       out  combinational hold request for IF/ID/EX
//   Done        out  one-cycle pulse; Result is valid in that cycle
//   Result      out  low WIDTH bits of A*B, held until the next Done or Reset
// -----------------------------------------------------------------------------
module mul_sequencer #(
  parameter int          WIDTH    = 32,
  parameter logic [3:0]  MUL_CODE = 4'd2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r,  state_nxt_s;
  logic [WIDTH-1:0] acc_r,    acc_nxt_s;
  logic [WIDTH-1:0] mcand_r,  mcand_nxt_s;
  logic [WIDTH-1:0] mplier_r, mplier_nxt_s;
  logic [CW-1:0]    cnt_r,    cnt_nxt_s;
  logic [WIDTH-1:0] result_r, result_nxt_s;
  logic             done_r,   done_nxt_s;

  logic             accept_s;
  logic             stall_s;
  logic [WIDTH-1:0] partial_s;
  logic [WIDTH-1:0] mplier_shr_s;

  // Accept decode and the per-iteration datapath terms.
  always_comb begin
    accept_s     = Start && (ALUControl == MUL_CODE) && !Flush;
    partial_s    = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    mplier_shr_s = mplier_r >> 1;
  end

  // Next-state, datapath updates and the combinational Stall request.
  always_comb begin
    state_nxt_s  = state_r;
    acc_nxt_s    = acc_r;
    mcand_nxt_s  = mcand_r;
    mplier_nxt_s = mplier_r;
    cnt_nxt_s    = cnt_r;
    result_nxt_s = result_r;
    done_nxt_s   = 1'b0;
    stall_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          stall_s      = 1'b1;
          state_nxt_s  = ST_BUSY;
          mcand_nxt_s  = A;
          mplier_nxt_s = B;
          acc_nxt_s    = {WIDTH{1'b0}};
          cnt_nxt_s    = {CW{1'b0}};
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end

      ST_BUSY: begin
        stall_s = 1'b1;
        if (Flush) begin
          // Squashed instruction: abandon the loop, Result keeps its old value.
          state_nxt_s = ST_IDLE;
        end else begin
          acc_nxt_s    = partial_s;
          mcand_nxt_s  = mcand_r << 1;
          mplier_nxt_s = mplier_shr_s;
          cnt_nxt_s    = cnt_r + CW'(1);
          // Stop early once no multiplier bits remain; the count bound only
          // matters when the top bit of B is set.
          if ((mplier_shr_s == {WIDTH{1'b0}}) || (cnt_r == CNT_LAST)) begin
            state_nxt_s  = ST_DONE;
            result_nxt_s = partial_s;
            done_nxt_s   = 1'b1;
          end else begin
            state_nxt_s  = ST_BUSY;
          end
        end
      end

      ST_DONE: begin
        // The mul is still in EX this cycle; going straight to IDLE without
        // looking at Start keeps it from being accepted a second time.
        state_nxt_s = ST_IDLE;
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      result_r <= {WIDTH{1'b0}};
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      acc_r    <= acc_nxt_s;
      mcand_r  <= mcand_nxt_s;
      mplier_r <= mplier_nxt_s;
      cnt_r    <= cnt_nxt_s;
      result_r <= result_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  // Output mapping: Done/Result come from registers, Stall must be
  // combinational so the pipeline holds in the accept cycle itself.
  always_comb begin
    Stall  = stall_s;
    Done   = done_r;
    Result = result_r;
  end

endmodule
